// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO
// Fixed 34-cycle latency for every op, including divide by zero.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] In1,
  input  logic [31:0] In2,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [4:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic        r_div_zero;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        r_is_div;
  logic        r_neg_a;
  logic        r_neg_b;
  logic        r_dz;
  logic [31:0] r_in1;
  logic [31:0] r_b;
  logic [31:0] r_acc;
  logic [31:0] r_q;

  logic        w_load;
  logic        w_iter;
  logic        w_fix;
  logic        w_mt_ok;

  logic        w_signed;
  logic [31:0] w_mag1;
  logic [31:0] w_mag2;
  logic [32:0] w_sum;
  logic [32:0] w_shift;
  logic [32:0] w_trial;
  logic        w_ge;
  logic [63:0] w_prod;
  logic [63:0] w_prod_fix;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;
  logic [31:0] w_hi_res;
  logic [31:0] w_lo_res;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (r_cnt == 5'd31) w_state_next = S_FIX;
      S_FIX:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_load  = 1'b0;
    w_iter  = 1'b0;
    w_fix   = 1'b0;
    w_mt_ok = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_load  = start;
        w_mt_ok = 1'b1;
      end
      S_RUN:   w_iter = 1'b1;
      S_FIX:   w_fix  = 1'b1;
      default: ;
    endcase
  end

  assign w_signed = ~op[0];
  assign w_mag1   = (w_signed && In1[31]) ? -In1 : In1;
  assign w_mag2   = (w_signed && In2[31]) ? -In2 : In2;

  // Multiply: add multiplicand when the low multiplier bit is set, then shift {acc, q} right.
  assign w_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : 33'd0);

  // Divide: shift next dividend bit into the remainder and try to subtract.
  assign w_shift = {r_acc, r_q[31]};
  assign w_ge    = (w_shift >= {1'b0, r_b});
  assign w_trial = w_shift - {1'b0, r_b};

  assign w_prod     = {r_acc, r_q};
  assign w_prod_fix = (r_neg_a ^ r_neg_b) ? -w_prod : w_prod;
  assign w_quo_fix  = (r_neg_a ^ r_neg_b) ? -r_q : r_q;
  assign w_rem_fix  = r_neg_a ? -r_acc : r_acc;

  always_comb begin
    w_hi_res = w_prod_fix[63:32];
    w_lo_res = w_prod_fix[31:0];
    if (r_is_div) begin
      if (r_dz) begin
        w_hi_res = r_in1;
        w_lo_res = 32'hFFFF_FFFF;
      end else begin
        w_hi_res = w_rem_fix;
        w_lo_res = w_quo_fix;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= 5'd0;
      r_is_div <= 1'b0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_dz     <= 1'b0;
      r_in1    <= 32'd0;
      r_b      <= 32'd0;
      r_acc    <= 32'd0;
      r_q      <= 32'd0;
    end else if (w_load) begin
      r_cnt    <= 5'd0;
      r_is_div <= op[1];
      r_neg_a  <= w_signed & In1[31];
      r_neg_b  <= w_signed & In2[31];
      r_dz     <= op[1] & (In2 == 32'd0);
      r_in1    <= In1;
      r_b      <= w_mag2;
      r_acc    <= 32'd0;
      r_q      <= w_mag1;
    end else if (w_iter) begin
      r_cnt <= r_cnt + 5'd1;
      if (r_is_div) begin
        r_acc <= w_ge ? w_trial[31:0] : w_shift[31:0];
        r_q   <= {r_q[30:0], w_ge};
      end else begin
        r_acc <= w_sum[32:1];
        r_q   <= {w_sum[0], r_q[31:1]};
      end
    end
  end

  // HI/LO change only on MTHI/MTLO in IDLE or on the FIX-state result write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_busy <= (w_state_next != S_IDLE);
      r_done <= w_fix;
      if (w_load)
        r_div_zero <= 1'b0;
      else if (w_fix)
        r_div_zero <= r_dz;
      if (w_fix) begin
        r_hi <= w_hi_res;
        r_lo <= w_lo_res;
      end else if (w_mt_ok) begin
        if (mthi) r_hi <= wdata;
        if (mtlo) r_lo <= wdata;
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - directed self-checking bench for muldiv_ctrl
module tb_muldiv_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] In1;
  logic [31:0] In2;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks;
  int n_errors;
  logic [31:0] m_hi;

  muldiv_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .In1      (In1),
    .In2      (In2),
    .mthi     (mthi),
    .mtlo     (mtlo),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz, input logic mt_at_start, input logic disturb);
    int n;
    int nb;
    start = 1'b1;
    op    = o;
    In1   = a;
    In2   = b;
    if (mt_at_start) begin
      mthi  = 1'b1;
      wdata = 32'h0000_0077;
      m_hi  = 32'h0000_0077;
    end
    nb = 0;
    n  = 0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      mthi  = 1'b0;
      if (busy) nb++;
      if (n == 1) begin
        check({tag, " dz_clear"}, {31'd0, div_zero}, 32'd0);
        if (mt_at_start) check({tag, " mthi_at_start"}, hi, 32'h0000_0077);
      end
      if (disturb && n == 5) begin
        start = 1'b1;
        op    = 2'b00;
        In1   = 32'd9;
        In2   = 32'd9;
        mthi  = 1'b1;
        wdata = 32'hDEAD_BEEF;
      end
      if (n == 20) check({tag, " hi_hold_run"}, hi, m_hi);
      if (done) break;
    end
    check({tag, " latency"}, n, 34);
    check({tag, " busy_cycles"}, nb, 33);
    check({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, " hi"}, hi, ehi);
    check({tag, " lo"}, lo, elo);
    check({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, edz});
    @(negedge clk);
    check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, " dz_sticky"}, {31'd0, div_zero}, {31'd0, edz});
    m_hi = ehi;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_hi  = 32'd0;
    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    In1   = 32'd0;
    In2   = 32'd0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    wdata = 32'd0;
    repeat (2) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset dz", {31'd0, div_zero}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b0, 1'b0);
    run_op("mult_min",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
    run_op("div_negb",  2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
    run_op("divu",      2'b11, 32'd7,         32'd2,         32'd1,         32'd3,         1'b0, 1'b0, 1'b0);
    run_op("div_wrap",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 1'b0, 1'b0);
    run_op("divu_zero", 2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_op("multu_clr", 2'b01, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0, 1'b1, 1'b0);

    mthi  = 1'b1;
    wdata = 32'h1234_5678;
    @(negedge clk);
    check("mthi", hi, 32'h1234_5678);
    mthi  = 1'b0;
    mtlo  = 1'b1;
    wdata = 32'h9ABC_DEF0;
    @(negedge clk);
    check("mtlo", lo, 32'h9ABC_DEF0);
    check("mtlo keeps hi", hi, 32'h1234_5678);
    mthi  = 1'b1;
    wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    check("mt both hi", hi, 32'hA5A5_A5A5);
    check("mt both lo", lo, 32'hA5A5_A5A5);
    m_hi = 32'hA5A5_A5A5;

    run_op("ignore_run", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0, 1'b1);

    start = 1'b1;
    op    = 2'b01;
    In1   = 32'hFFFF;
    In2   = 32'hFFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_hi  = 32'd0;
    @(negedge clk);
    check("post reset busy", {31'd0, busy}, 32'd0);
    run_op("multu_after_rst", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
